nanov_fetch_sequencer: RTL and testbench
========================================

Name: nanov_fetch_sequencer

Overview:
- Upstream stage of the bit-serial core. Streams instructions from SPI flash using the 0x03 read command and holds the current 32-bit instruction.
- Generates the core's counter and cycle sequencing and keeps the program counter, presenting it serially to the core.
- Prefetches the next instruction while the current one executes; restarts the flash read on a taken branch or jump.

Parameters:
- PC_BITS, 22, width of the stored PC (flash address space 2^PC_BITS bytes).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- spi_miso  in  1  flash serial data, sampled on clk rising edges where spi_clk_en=1
- spi_select  out  1  flash chip select, active low
- spi_clk_en  out  1  SPI clock gate; top level drives the flash clock from clk gated by this
- spi_mosi  out  1  flash command/address bit, MSB first
- branch  in  1  core branch/jump-taken strobe
- shift_pc  in  1  core request to rotate the PC by one bit
- data_out  in  32  core buffered data; branch target in bits [PC_BITS-1:0]
- instr  out  32  current instruction to the core
- cycle  out  3  current instruction cycle (0 or 1)
- counter  out  5  bit index within a cycle, 0..31
- pc  out  1  serial PC bit for the core

Behaviour:
- Reset (asynchronous, rst=1):
  - spi_select=1, spi_clk_en=0, spi_mosi=0.
  - instr=0x00000013 (NOP), counter=0, cycle=0.
  - pc_reg=RESET_PC, state=RESTART.
  - Reset mid-fetch or mid-execute abandons everything; the sequence starts again from RESTART.
- States: RESTART -> CMD -> ADDR -> DATA -> EXEC.
  - RESTART: 1 clk; spi_select=1, spi_clk_en=0.
  - CMD: 8 clks; select low, clk_en=1; mosi carries 0x03 MSB first.
  - ADDR: 24 clks; mosi carries {zero pad, pc_reg}, MSB first.
  - DATA: 32 clks; miso bits are assembled into instr_next.
  - EXEC: entered with instr<=instr_next.
- Flash byte order: stream bit k (k=0..31) goes to instr bit 8*(k/8)+7-(k%8), i.e. little-endian bytes, MSB first within each byte.
- Outside EXEC, instr=NOP and counter/cycle are held at 0, so the core writes nothing. Reset-to-first-EXEC latency is 65 clks.
- EXEC:
  - counter increments every clk and wraps 31->0.
  - NCYC=2 when opcode[6:2] is 11011, 11001 or 11000, or when opcode[6:2] is 00100 or 01100 with funct3[1:0]=01. Otherwise NCYC=1.
  - cycle increments on counter wrap while cycle<NCYC-1.
- Prefetch:
  - During cycle 0, the flash keeps streaming: select stays low, clk_en=1, and 32 bits fill instr_next.
  - During cycle 1, clk_en=0; the stream stalls and select stays low.
- PC:
  - pc = pc_reg[0] when shift_pc=1, else 0.
  - On shift_pc, pc_reg rotates right by one bit. PC_BITS shifts per cycle restore the value exactly.
- Branch:
  - The branch strobe is latched into branch_taken during the instruction.
  - branch_taken is cleared at instruction end.
- Instruction end (counter=31 in the final cycle):
  - Not taken: pc_reg<=pc_reg+4 (modulo 2^PC_BITS), instr<=instr_next, counter=0, cycle=0; back-to-back execution with no gap.
  - Taken: pc_reg<=data_out[PC_BITS-1:0] on that edge, instr_next is discarded, state=RESTART.
- A branch strobe that coincides with the instruction-end clock counts as taken.
- If shift_pc arrives outside EXEC, pc_reg still rotates; the core guarantees this does not occur.

Decomposition:
- Shared package nanov_pkg:
  - NOP_INSTR=0x00000013, SPI_READ_CMD=8'h03.
  - Opcode constants OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_REG.
  - Fetch state enum.
- One sub-module, nanov_spi_stream:
  - Owns select, clk_en, mosi and the bit counter.
  - Performs the byte-reordered assembly of instr_next.
  - Inputs: restart, stall. Output: word_valid.

Test Plan:
- Reset: release rst with the flash model holding 0x00500093 at address 0 -> mosi shows 0x03 then 24 zero address bits; EXEC starts 65 clks after release with instr=0x00500093 and cycle=0.
- Sequential: words 0x00100093 and 0x00200113 at 0 and 4 -> the second instr appears exactly 32 clks after the first; pc_reg=8 after the second; select never rises.
- Two-cycle shift: slli 0x00309093 -> cycle reaches 1 for 32 clks with spi_clk_en=0 throughout; the next instr follows with no lost bits.
- Taken branch: branch pulse with data_out=0x00000100 -> select high for 1 clk, address 0x000100 on mosi, next EXEC 65 clks after the instruction end.
- PC rotation: shift_pc held for 22 clks with pc_reg=0x000024 -> serial pc bits are 0,0,1,0,0,1,0…; pc_reg equals 0x000024 afterwards.
- Reset mid-ADDR: rst asserted at ADDR bit 10 -> select=1 and instr=NOP immediately; a clean 0x03 sequence restarts after release.

Source files
------------

// File: rtl/nanov_pkg.sv
// Shared constants, fetch state encoding and opcode decode for the nanov fetch path.
package nanov_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [7:0]  SPI_READ_CMD = 8'h03;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int WORD_BITS = 32;

    // opcode[6:2] values
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_REG    = 5'b01100;

    typedef enum logic [2:0] {
        ST_RESTART,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_EXEC
    } fetch_state_e;

    // Jumps, branches and shifts need a second 32-bit cycle in the core.
    function automatic logic two_cycle(input logic [4:0] op, input logic [1:0] f3);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH) ||
               (((op == OP_IMM) || (op == OP_REG)) && (f3 == 2'b01));
    endfunction

endpackage

// File: rtl/nanov_spi_stream.sv
// SPI flash read streamer: issues 0x03 + 24-bit address, then assembles
// little-endian instruction words from the continuous data stream.
module nanov_spi_stream
    import nanov_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        stall,
    input  logic [23:0] addr,
    input  logic        spi_miso,
    output logic        spi_select,
    output logic        spi_clk_en,
    output logic        spi_mosi,
    output logic [31:0] instr_next,
    output logic        phase_done,
    output logic        word_valid
);

    fetch_state_e phase;
    logic [4:0]   bit_cnt;
    logic [4:0]   last_bit;
    logic [4:0]   dst;
    logic [31:0]  tx_sr;
    logic [31:0]  rx_word;
    logic         in_restart;

    assign in_restart = restart || (phase == ST_RESTART);
    assign spi_select = in_restart;
    assign spi_clk_en = !in_restart && !stall;
    assign spi_mosi   = !in_restart && ((phase == ST_CMD) || (phase == ST_ADDR)) && tx_sr[31];

    always_comb begin
        case (phase)
            ST_CMD:  last_bit = 5'(CMD_BITS - 1);
            ST_ADDR: last_bit = 5'(ADDR_BITS - 1);
            default: last_bit = 5'(WORD_BITS - 1);
        endcase
    end

    assign phase_done = spi_clk_en && (bit_cnt == last_bit);
    assign word_valid = phase_done && (phase == ST_DATA);

    // Stream bit k lands at instr bit k^7: bytes little-endian, MSB first within a byte.
    assign dst = bit_cnt ^ 5'd7;

    always_comb begin
        instr_next = rx_word;
        if (spi_clk_en && (phase == ST_DATA))
            instr_next[dst] = spi_miso;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= ST_RESTART;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_word <= '0;
        end else if (in_restart) begin
            phase   <= ST_CMD;
            bit_cnt <= '0;
            tx_sr   <= {SPI_READ_CMD, addr};
        end else if (spi_clk_en) begin
            rx_word <= instr_next;
            tx_sr   <= {tx_sr[30:0], 1'b0};
            if (phase_done) begin
                bit_cnt <= '0;
                if (phase == ST_CMD)
                    phase <= ST_ADDR;
                else if (phase == ST_ADDR)
                    phase <= ST_DATA;
            end else begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/nanov_fetch_sequencer.sv
// Fetch/sequencing front end of the bit-serial core: holds the current
// instruction and PC, prefetches over SPI and restarts the read on taken branches.
module nanov_fetch_sequencer
    import nanov_pkg::*;
#(
    parameter int unsigned          PC_BITS  = 22,
    parameter logic [PC_BITS-1:0]   RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_miso,
    output logic        spi_select,
    output logic        spi_clk_en,
    output logic        spi_mosi,
    input  logic        branch,
    input  logic        shift_pc,
    input  logic [31:0] data_out,
    output logic [31:0] instr,
    output logic [2:0]  cycle,
    output logic [4:0]  counter,
    output logic        pc
);

    fetch_state_e       state, state_nx;
    logic [PC_BITS-1:0] pc_reg;
    logic [31:0]        instr_q;
    logic [31:0]        instr_next;
    logic [4:0]         counter_q;
    logic [2:0]         cycle_q;
    logic               branch_taken;
    logic               phase_done, word_valid;
    logic               is_exec, last_cycle, instr_end, taken;

    nanov_spi_stream u_stream (
        .clk        (clk),
        .rst        (rst),
        .restart    (state == ST_RESTART),
        .stall      (is_exec && (cycle_q != 3'd0)),
        .addr       (24'(pc_reg)),
        .spi_miso   (spi_miso),
        .spi_select (spi_select),
        .spi_clk_en (spi_clk_en),
        .spi_mosi   (spi_mosi),
        .instr_next (instr_next),
        .phase_done (phase_done),
        .word_valid (word_valid)
    );

    assign is_exec    = (state == ST_EXEC);
    assign last_cycle = two_cycle(instr_q[6:2], instr_q[13:12]) ? (cycle_q == 3'd1) : (cycle_q == 3'd0);
    assign instr_end  = is_exec && (counter_q == 5'd31) && last_cycle;
    assign taken      = branch_taken || branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RESTART;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RESTART: state_nx = ST_CMD;
            ST_CMD:     if (phase_done) state_nx = ST_ADDR;
            ST_ADDR:    if (phase_done) state_nx = ST_DATA;
            ST_DATA:    if (word_valid) state_nx = ST_EXEC;
            ST_EXEC:    if (instr_end && taken) state_nx = ST_RESTART;
            default:    state_nx = ST_RESTART;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            instr_q      <= NOP_INSTR;
            counter_q    <= '0;
            cycle_q      <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (shift_pc)
                pc_reg <= {pc_reg[0], pc_reg[PC_BITS-1:1]};
            if ((state == ST_DATA) && word_valid) begin
                instr_q   <= instr_next;
                counter_q <= '0;
                cycle_q   <= '0;
            end else if (is_exec) begin
                counter_q <= counter_q + 5'd1;
                if (branch)
                    branch_taken <= 1'b1;
                // Instruction end overrides any rotate requested on the same edge.
                if (instr_end) begin
                    cycle_q      <= '0;
                    branch_taken <= 1'b0;
                    if (taken) begin
                        pc_reg  <= data_out[PC_BITS-1:0];
                        instr_q <= NOP_INSTR;
                    end else begin
                        pc_reg  <= pc_reg + PC_BITS'(4);
                        instr_q <= instr_next;
                    end
                end else if (counter_q == 5'd31) begin
                    cycle_q <= cycle_q + 3'd1;
                end
            end
        end
    end

    if (PC_BITS < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^data_out[31:PC_BITS];
    end

    assign instr   = instr_q;
    assign counter = counter_q;
    assign cycle   = cycle_q;
    assign pc      = shift_pc & pc_reg[0];

endmodule

// File: tb/tb_nanov_fetch_sequencer.sv
// Bench for nanov_fetch_sequencer: byte-wide SPI flash model, scoreboard of
// expected instruction starts and a table of program steps.
module tb_nanov_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_miso, spi_select, spi_clk_en, spi_mosi;
    logic        branch = 1'b0, shift_pc = 1'b0, pc;
    logic [31:0] data_out = '0, instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nanov_fetch_sequencer #(.PC_BITS(22), .RESET_PC(22'h0)) dut (
        .clk(clk), .rst(rst), .spi_miso(spi_miso), .spi_select(spi_select),
        .spi_clk_en(spi_clk_en), .spi_mosi(spi_mosi), .branch(branch),
        .shift_pc(shift_pc), .data_out(data_out), .instr(instr),
        .cycle(cycle), .counter(counter), .pc(pc)
    );

    // ---------------- flash model ----------------
    logic [7:0]  mem [0:511];
    int unsigned fbits = 0;
    int unsigned fd = 0;
    logic [31:0] fin = '0;
    logic [7:0]  fcmd = '0;
    logic [23:0] faddr = '0;
    logic [23:0] fa;

    always @(posedge clk) begin
        if (spi_select) begin
            fbits <= 0;
            fd    <= 0;
        end else if (spi_clk_en) begin
            if (fbits < 32) begin
                fin   <= {fin[30:0], spi_mosi};
                fbits <= fbits + 1;
                if (fbits == 31) begin
                    fcmd  <= fin[30:23];
                    faddr <= {fin[22:0], spi_mosi};
                end
            end else begin
                fd <= fd + 1;
            end
        end
    end

    always_comb begin
        fa       = '0;
        spi_miso = 1'b0;
        if (fbits >= 32) begin
            fa       = faddr + 24'(fd >> 3);
            spi_miso = mem[fa[8:0]][3'd7 - 3'(fd % 8)];
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] word;
        int          ncyc;
        int          br;      // 0 none, 1 early pulse, 2 on the instruction-end clock
        logic [21:0] tgt;
        logic [21:0] pc;
        int          gap;     // clocks from previous instruction start (or reset release)
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        int          gap;
        bit          chk_addr;
        logic [23:0] faddr;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[9];
    int   n_chk = 0, n_pass = 0;
    int   last_start = 0;
    bit   abort = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic tick(input logic sp, input logic br);
        @(negedge clk);
        shift_pc = sp;
        branch   = br;
        #1;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        #1;
        last_start = cyc;
    endtask

    task automatic wait_start();
        int   n = 0;
        exp_t e;
        tick(1'b0, 1'b0);
        while (!(counter == 5'd0 && cycle == 3'd0 && instr !== NOP) && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
        end
        if (n >= 300 || sbq.size() == 0) begin
            n_chk++;
            $display("FAIL start: no instruction start within bound (waited %0d, queued %0d)", n, sbq.size());
            abort = 1;
            return;
        end
        e = sbq.pop_front();
        chk("instr", instr, e.instr);
        chk("start_gap", 32'(cyc - last_start), 32'(e.gap));
        chk("spi_cmd", {24'h0, fcmd}, 32'h03);
        if (e.chk_addr) chk("fetch_addr", {8'h0, faddr}, {8'h0, e.faddr});
        last_start = cyc;
    endtask

    task automatic run_instr(input vec_t v);
        int          n = 32 * v.ncyc;
        int          bad = 0;
        logic [21:0] got = '0;
        data_out = (v.br != 0) ? 32'(v.tgt) : $urandom;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick(k <= 22, (v.br == 1 && k == 5) || (v.br == 2 && k == n - 1));
            if (k >= 1 && k <= 22) got[k-1] = pc;
            if (spi_select !== 1'b0 || spi_clk_en !== (k < 32) ||
                counter !== 5'(k % 32) || cycle !== 3'(k / 32)) bad++;
        end
        chk("exec_seq", 32'(bad), 32'h0);
        chk("serial_pc", {10'h0, got}, {10'h0, v.pc});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h00100093, 1, 0, 22'h000, 22'h000, 65};
        vecs[1] = '{32'h00200113, 1, 0, 22'h000, 22'h004, 32};
        vecs[2] = '{32'h00309093, 2, 0, 22'h000, 22'h008, 32};
        vecs[3] = '{32'h00000063, 2, 1, 22'h100, 22'h00C, 64};
        vecs[4] = '{32'h00209033, 2, 0, 22'h000, 22'h100, 129};
        vecs[5] = '{32'h0000006F, 2, 2, 22'h024, 22'h104, 64};
        vecs[6] = '{32'h00500093, 1, 0, 22'h000, 22'h024, 129};
        vecs[7] = '{32'h00108067, 2, 0, 22'h000, 22'h028, 32};
        vecs[8] = '{32'h00700193, 1, 0, 22'h000, 22'h02C, 64};

        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        put_word(0, 32'h00500093);

        // reset state
        repeat (3) tick(1'b0, 1'b0);
        chk("rst_select", {31'h0, spi_select}, 32'h1);
        chk("rst_clk_en", {31'h0, spi_clk_en}, 32'h0);
        chk("rst_mosi", {31'h0, spi_mosi}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_counter", {27'h0, counter}, 32'h0);
        chk("rst_cycle", {29'h0, cycle}, 32'h0);

        // reset in the middle of the address phase
        release_rst();
        repeat (19) tick(1'b0, 1'b0);
        chk("addr_bits_sent", 32'(fbits), 32'd18);
        rst = 1'b1;
        #1;
        chk("midrst_select", {31'h0, spi_select}, 32'h1);
        chk("midrst_clk_en", {31'h0, spi_clk_en}, 32'h0);
        chk("midrst_mosi", {31'h0, spi_mosi}, 32'h0);
        chk("midrst_instr", instr, NOP);
        repeat (2) tick(1'b0, 1'b0);
        release_rst();
        sbq.push_back('{instr: 32'h00500093, gap: 65, chk_addr: 1'b1, faddr: 24'h0});
        wait_start();

        // main program
        rst = 1'b1;
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        for (int i = 0; i < 9; i++) begin
            put_word(int'(vecs[i].pc), vecs[i].word);
            sbq.push_back('{instr: vecs[i].word, gap: vecs[i].gap,
                            chk_addr: (i == 0) || (vecs[(i > 0) ? i - 1 : 0].br != 0),
                            faddr: 24'(vecs[i].pc)});
        end
        repeat (2) tick(1'b0, 1'b0);
        release_rst();
        for (int i = 0; i < 9; i++) begin
            if (!abort) wait_start();
            if (!abort) run_instr(vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
